ex_div: RTL and testbench

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_pkg.sv | 24 ++
 rtl/div_step.sv | 30 +++
 rtl/ex_div.sv | 130 +++++++++++++
 tb/tb_ex_div.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_pkg
// Purpose  : Shared state encodings and handshake constants for the divider.
// Revision : 1.0
// ============================================================================
package ex_div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring shift-subtract iteration.
// Revision : 1.0
// ============================================================================
module div_step
   import ex_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] partial_d;
   logic [WIDTH:0] diff_d;

   // rem_i < divisor_i keeps the difference within WIDTH+1 signed bits,
   // so its MSB is the borrow.
   assign partial_d = {rem_i, bit_i};
   assign diff_d    = partial_d - {1'b0, divisor_i};
   assign q_o       = ~diff_d[WIDTH];
   assign rem_o     = q_o ? diff_d[WIDTH-1:0] : partial_d[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module   : ex_div
// Purpose  : Multi-cycle signed/unsigned restoring divider for the EX stage.
// Revision : 1.0
// ============================================================================
module ex_div
   import ex_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic             neg_quo_q;
   logic             neg_rem_q;

   logic             neg1_d;
   logic             neg2_d;
   logic [WIDTH-1:0] mag1_d;
   logic [WIDTH-1:0] mag2_d;
   logic [WIDTH-1:0] rem_d;
   logic             qbit_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] quo_fix_d;
   logic [WIDTH-1:0] rem_fix_d;

   assign neg1_d = signed_div_i & opdata1_i[WIDTH-1];
   assign neg2_d = signed_div_i & opdata2_i[WIDTH-1];
   assign mag1_d = neg1_d ? -opdata1_i : opdata1_i;
   assign mag2_d = neg2_d ? -opdata2_i : opdata2_i;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (rem_d),
      .q_o       (qbit_d)
   );

   // The dividend register shifts left; freed LSBs collect quotient bits.
   assign quo_d     = {dvd_q[WIDTH-2:0], qbit_d};
   assign quo_fix_d = neg_quo_q ? -quo_d : quo_d;
   assign rem_fix_d = neg_rem_q ? -rem_d : rem_d;

   assign busy_o = (state_q == DivByZero) || (state_q == DivOn);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_o  <= '0;
         ready_o   <= DivResultNotReady;
      end else begin
         case (state_q)
            DivFree: begin
               if (start_i == DivStart) begin
                  cnt_q     <= '0;
                  rem_q     <= '0;
                  dvs_q     <= mag2_d;
                  neg_quo_q <= neg1_d ^ neg2_d;
                  neg_rem_q <= neg1_d;
                  if (opdata2_i == '0) begin
                     state_q <= DivByZero;
                     dvd_q   <= opdata1_i;
                  end else begin
                     state_q <= DivOn;
                     dvd_q   <= mag1_d;
                  end
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else begin
                  state_q  <= DivEnd;
                  result_o <= {dvd_q, {WIDTH{1'b1}}};
                  ready_o  <= DivResultReady;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state_q <= DivFree;
                  cnt_q   <= '0;
               end else begin
                  dvd_q <= quo_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     state_q  <= DivEnd;
                     result_o <= {rem_fix_d, quo_fix_d};
                     ready_o  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (annul_i || (start_i == DivStop)) begin
                  state_q  <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end
            default: state_q <= DivFree;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_div
// Purpose  : Scoreboard bench for ex_div (latency, signed/unsigned, abort, reset).
// Revision : 1.0
// ============================================================================
module tb_ex_div;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start_i;
   logic           signed_div_i;
   logic [W-1:0]   opdata1_i;
   logic [W-1:0]   opdata2_i;
   logic           annul_i;
   logic [2*W-1:0] result_o;
   logic           ready_o;
   logic           busy_o;

   int             n_run  = 0;
   int             n_fail = 0;
   logic [2*W-1:0] sb_q[$];

   ex_div #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
      longint      sa;
      longint      sb;
      logic [63:0] q;
      logic [63:0] r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = {32'd0, a} / {32'd0, b};
         r = {32'd0, a} % {32'd0, b};
      end
      return {r[31:0], q[31:0]};
   endfunction

   // Launch with start held, scramble operands after acceptance, wait for ready.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int lat, input bit tog, input string tag,
                          input logic [63:0] exp);
      int          n;
      logic [63:0] e;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sgn;
      start_i      = 1'b1;
      cyc();
      sb_q.push_back(exp);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~sgn;
      chk({tag, " busy"}, 64'(busy_o), 64'd1);
      n = 0;
      while (!ready_o && n < lat + 8) begin
         if (tog) start_i = (n >= 2 && n < 10) ? n[0] : 1'b1;
         cyc();
         n++;
      end
      e = sb_q.pop_front();
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " ready"}, 64'(ready_o), 64'd1);
      if (ready_o) begin
         chk({tag, " busy end"}, 64'(busy_o), 64'd0);
         chk({tag, " result"}, result_o, e);
         cyc();
         chk({tag, " hold"}, result_o, e);
      end
      start_i = 1'b0;
      cyc();
      chk({tag, " idle ready"}, 64'(ready_o), 64'd0);
      chk({tag, " idle result"}, result_o, 64'd0);
   endtask

   initial begin
      int          seen;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      #1;
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset busy", 64'(busy_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      cyc();
      cyc();
      rst = 1'b0;

      run_div(32'd100, 32'd7, 1'b0, 32, 1'b0, "u100/7", {32'h2, 32'hE});
      run_div(-32'sd7, 32'd2, 1'b1, 32, 1'b1, "s-7/2", {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div(32'd5, 32'd0, 1'b0, 1, 1'b0, "u5/0", {32'h5, 32'hFFFF_FFFF});
      run_div(32'd5, 32'd0, 1'b1, 1, 1'b0, "s5/0", {32'h5, 32'hFFFF_FFFF});
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32, 1'b0, "smin/-1", {32'h0, 32'h8000_0000});
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32, 1'b0, "umin/max", {32'h8000_0000, 32'h0});

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         rs = 1'($urandom_range(0, 1));
         run_div(ra, rb, rs, (rb == 0) ? 1 : 32, 1'b0, "rand", model(ra, rb, rs));
      end

      // Abort at iteration 10; no result may ever appear for it.
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      cyc();
      start_i = 1'b0;
      repeat (10) cyc();
      annul_i = 1'b1;
      cyc();
      annul_i = 1'b0;
      chk("annul busy", 64'(busy_o), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o) seen++;
         cyc();
      end
      chk("annul no ready", 64'(seen), 64'd0);
      run_div(32'd9, 32'd3, 1'b0, 32, 1'b0, "u9/3", {32'd0, 32'd3});

      // Abort while in END with start still high.
      opdata1_i = 32'd20;
      opdata2_i = 32'd6;
      start_i   = 1'b1;
      cyc();
      seen = 0;
      while (!ready_o && seen < 40) begin
         cyc();
         seen++;
      end
      chk("end reached", 64'(ready_o), 64'd1);
      annul_i = 1'b1;
      cyc();
      annul_i = 1'b0;
      start_i = 1'b0;
      chk("end annul ready", 64'(ready_o), 64'd0);
      chk("end annul result", result_o, 64'd0);
      cyc();
      chk("end annul busy", 64'(busy_o), 64'd0);

      // Asynchronous reset mid-iteration, with start toggling during ON.
      opdata1_i = 32'd12345;
      opdata2_i = 32'd17;
      start_i   = 1'b1;
      cyc();
      for (int i = 0; i < 20; i++) begin
         start_i = i[0];
         cyc();
      end
      chk("pre-reset busy", 64'(busy_o), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("async rst busy", 64'(busy_o), 64'd0);
      chk("async rst ready", 64'(ready_o), 64'd0);
      chk("async rst result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_div(32'd77, 32'd10, 1'b0, 32, 1'b0, "post-rst", {32'd7, 32'd7});

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
      $fatal(1);
   end

endmodule
`default_nettype wire
